// File: rtl/hand_sorter.sv
// Card-hand register file that collects HAND_SIZE cards, then sorts them in place
// with an odd-even transposition network (one phase per clock) and flags duplicates.
module hand_sorter #(
    parameter int HAND_SIZE = 5,
    parameter int CARD_W = 6,
    localparam int AW = $clog2(HAND_SIZE)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                we,
    input  logic [AW-1:0]                       waddr,
    input  logic [CARD_W-1:0]                   card_in,
    input  logic                                clr,
    input  logic                                desc,
    output logic                                hand_full,
    output logic                                sorting,
    output logic                                sort_done,
    output logic                                dup_found,
    output logic                                addr_err,
    output logic                                wr_rej,
    output logic [HAND_SIZE-1:0][CARD_W-1:0]    hand
);

    typedef enum logic [1:0] {FILL, SORT, DONE} state_t;

    localparam logic [AW:0]   SLOTS      = (AW+1)'(HAND_SIZE);
    localparam logic [AW-1:0] LAST_PHASE = AW'(HAND_SIZE - 1);

    state_t                             state;
    state_t                             state_next;
    logic [HAND_SIZE-1:0]               valid;
    logic [AW-1:0]                      phase;
    logic                               desc_q;
    logic                               addr_ok;
    logic [HAND_SIZE-1:0][CARD_W-1:0]   swapped;

    assign hand_full = &valid;
    assign sorting   = (state == SORT);
    assign sort_done = (state == DONE);
    assign addr_ok   = ({1'b0, waddr} < SLOTS);

    always_ff @(posedge clk) begin
        if (rst) state <= FILL;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (clr) begin
            state_next = FILL;
        end else begin
            case (state)
                FILL:    if (hand_full) state_next = SORT;
                SORT:    if (phase == LAST_PHASE) state_next = DONE;
                DONE:    state_next = DONE;
                default: state_next = FILL;
            endcase
        end
    end

    // Even phases pair (0,1),(2,3)..; odd phases pair (1,2),(3,4)..; pairs are disjoint.
    always_comb begin
        swapped = hand;
        for (int i = 0; i < HAND_SIZE - 1; i++) begin
            if ((i % 2 == 1) == phase[0]) begin
                if (desc_q ? (hand[i] < hand[i+1]) : (hand[i] > hand[i+1])) begin
                    swapped[i]   = hand[i+1];
                    swapped[i+1] = hand[i];
                end
            end
        end
    end

    always_comb begin
        dup_found = 1'b0;
        if (state == DONE) begin
            for (int i = 0; i < HAND_SIZE - 1; i++) begin
                if (hand[i] == hand[i+1]) dup_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hand     <= '0;
            valid    <= '0;
            phase    <= '0;
            desc_q   <= 1'b0;
            addr_err <= 1'b0;
            wr_rej   <= 1'b0;
        end else begin
            addr_err <= 1'b0;
            wr_rej   <= 1'b0;
            if (clr) begin
                hand  <= '0;
                valid <= '0;
                phase <= '0;
            end else begin
                case (state)
                    FILL: begin
                        if (hand_full) begin
                            // Hand is closed on this edge: latch order, reject any write.
                            desc_q <= desc;
                            phase  <= '0;
                            if (we) wr_rej <= 1'b1;
                        end else if (we) begin
                            if (addr_ok) begin
                                for (int i = 0; i < HAND_SIZE; i++) begin
                                    if (waddr == AW'(i)) begin
                                        hand[i]  <= card_in;
                                        valid[i] <= 1'b1;
                                    end
                                end
                            end else begin
                                addr_err <= 1'b1;
                            end
                        end
                    end
                    SORT: begin
                        hand  <= swapped;
                        phase <= phase + AW'(1);
                        if (we) wr_rej <= 1'b1;
                    end
                    DONE: begin
                        if (we) wr_rej <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hand_sorter.sv
// Bench for hand_sorter: randomized hands against a queue-sort reference model,
// plus directed fill/error/abort cases and HAND_SIZE=2/8 instances with 8-bit cards.
module tb_hand_sorter;

    localparam int HS = 5;
    localparam int CW = 6;
    localparam int AW = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // main instance
    logic rst, we, clr, desc;
    logic [AW-1:0] waddr;
    logic [CW-1:0] card_in;
    logic hand_full, sorting, sort_done, dup_found, addr_err, wr_rej;
    logic [HS-1:0][CW-1:0] hand;

    hand_sorter #(.HAND_SIZE(HS), .CARD_W(CW)) dut (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .card_in(card_in), .clr(clr),
        .desc(desc), .hand_full(hand_full), .sorting(sorting), .sort_done(sort_done),
        .dup_found(dup_found), .addr_err(addr_err), .wr_rej(wr_rej), .hand(hand)
    );

    // two-slot instance
    logic s2_rst, s2_we, s2_clr, s2_desc;
    logic [0:0] s2_waddr;
    logic [7:0] s2_card;
    logic s2_full, s2_sorting, s2_done, s2_dup, s2_aerr, s2_rej;
    logic [1:0][7:0] s2_hand;

    hand_sorter #(.HAND_SIZE(2), .CARD_W(8)) dut2 (
        .clk(clk), .rst(s2_rst), .we(s2_we), .waddr(s2_waddr), .card_in(s2_card), .clr(s2_clr),
        .desc(s2_desc), .hand_full(s2_full), .sorting(s2_sorting), .sort_done(s2_done),
        .dup_found(s2_dup), .addr_err(s2_aerr), .wr_rej(s2_rej), .hand(s2_hand)
    );

    // eight-slot instance
    logic s8_rst, s8_we, s8_clr, s8_desc;
    logic [2:0] s8_waddr;
    logic [7:0] s8_card;
    logic s8_full, s8_sorting, s8_done, s8_dup, s8_aerr, s8_rej;
    logic [7:0][7:0] s8_hand;

    hand_sorter #(.HAND_SIZE(8), .CARD_W(8)) dut8 (
        .clk(clk), .rst(s8_rst), .we(s8_we), .waddr(s8_waddr), .card_in(s8_card), .clr(s8_clr),
        .desc(s8_desc), .hand_full(s8_full), .sorting(s8_sorting), .sort_done(s8_done),
        .dup_found(s8_dup), .addr_err(s8_aerr), .wr_rej(s8_rej), .hand(s8_hand)
    );

    // scoreboards: {dup, hand} for main, hand only for the side instances
    logic [HS*CW:0] exp_q[$];
    logic [15:0]    s2_q[$];
    logic [63:0]    s8_q[$];

    // reference model of the main instance
    logic [CW-1:0] m_hand[HS];
    bit            m_valid[HS];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit m_full();
        bit f = 1'b1;
        for (int i = 0; i < HS; i++) f &= m_valid[i];
        return f;
    endfunction

    function automatic logic [HS*CW-1:0] model_vec();
        logic [HS*CW-1:0] v;
        for (int i = 0; i < HS; i++) v[i*CW +: CW] = m_hand[i];
        return v;
    endfunction

    function automatic logic [HS*CW:0] expect_result(input bit d);
        int q[$];
        logic [HS*CW:0] r;
        for (int i = 0; i < HS; i++) q.push_back(int'(m_hand[i]));
        if (d) q.rsort();
        else   q.sort();
        r = '0;
        for (int i = 0; i < HS; i++) r[i*CW +: CW] = CW'(q[i]);
        for (int i = 0; i < HS - 1; i++) if (q[i] == q[i+1]) r[HS*CW] = 1'b1;
        return r;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < HS; i++) begin
            m_hand[i]  = '0;
            m_valid[i] = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- monitors ----------------
    bit main_prev = 1'b0;
    logic [HS*CW:0] main_e;
    always @(negedge clk) begin
        if (sort_done && !main_prev) begin
            if (exp_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_done: sort_done rose with no expected hand (t=%0t)", $time);
            end else begin
                main_e = exp_q.pop_front();
                check("sorted_hand", 64'(hand), 64'(main_e[HS*CW-1:0]));
                check("dup_found", 64'(dup_found), 64'(main_e[HS*CW]));
            end
        end
        main_prev = sort_done;
    end

    bit s2_prev = 1'b0;
    logic [15:0] s2_e;
    always @(negedge clk) begin
        if (s2_done && !s2_prev) begin
            if (s2_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL s2_unexpected_done: got sort_done=1, expected 0");
            end else begin
                s2_e = s2_q.pop_front();
                check("s2_hand", 64'(s2_hand), 64'(s2_e));
            end
        end
        s2_prev = s2_done;
    end

    bit s8_prev = 1'b0;
    logic [63:0] s8_e;
    always @(negedge clk) begin
        if (s8_done && !s8_prev) begin
            if (s8_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL s8_unexpected_done: got sort_done=1, expected 0");
            end else begin
                s8_e = s8_q.pop_front();
                check("s8_hand", 64'(s8_hand), s8_e);
            end
        end
        s8_prev = s8_done;
    end

    // ---------------- driver tasks (main instance) ----------------
    task automatic do_reset();
        rst = 1'b1; we = 1'b0; clr = 1'b0;
        tick();
        rst = 1'b0;
        model_clear();
        check("reset_outputs",
              64'({hand, hand_full, sorting, sort_done, dup_found, addr_err, wr_rej}), 64'(0));
    endtask

    task automatic wr(input int a, input int v);
        we = 1'b1; waddr = AW'(a); card_in = CW'(v);
        tick();
        we = 1'b0;
        if (a < HS) begin
            m_hand[a]  = CW'(v);
            m_valid[a] = 1'b1;
        end
        check("addr_err", 64'(addr_err), 64'(a >= HS));
        check("wr_rej_fill", 64'(wr_rej), 64'(0));
        check("hand_after_write", 64'(hand), 64'(model_vec()));
        check("hand_full", 64'(hand_full), 64'(m_full()));
    endtask

    task automatic sort_run(input bit d, input bit poke);
        logic [HS*CW:0] e;
        int n;
        desc = d;
        e = expect_result(d);
        exp_q.push_back(e);
        n = 0;
        for (int k = 0; k < 30; k++) begin
            tick();
            n++;
            if (n == 1) begin
                check("sorting_started", 64'(sorting), 64'(1));
                if (poke) begin
                    desc = ~d;
                    we = 1'b1;
                    waddr = AW'($urandom_range(0, 7));
                    card_in = CW'($urandom_range(0, 63));
                end
            end
            if (n == 2 && poke) begin
                we = 1'b0;
                check("wr_rej_sort", 64'(wr_rej), 64'(1));
                check("no_addr_err_sort", 64'(addr_err), 64'(0));
            end
            if (sort_done) break;
        end
        check("done_latency", 64'(n), 64'(HS + 1));
        desc = d;
        we = 1'b1; waddr = AW'($urandom_range(0, 4)); card_in = CW'($urandom_range(0, 63));
        tick();
        we = 1'b0;
        check("wr_rej_done", 64'(wr_rej), 64'(1));
        tick();
        check("done_hold", 64'({sort_done, hand}), 64'({1'b1, e[HS*CW-1:0]}));
    endtask

    task automatic do_clear(input bit with_write);
        clr = 1'b1; we = with_write;
        waddr = AW'($urandom_range(0, 7)); card_in = CW'($urandom_range(1, 63));
        tick();
        clr = 1'b0; we = 1'b0;
        model_clear();
        check("clear_state",
              64'({hand, hand_full, sorting, sort_done, dup_found, addr_err, wr_rej}), 64'(0));
    endtask

    task automatic abort_run(input bit use_rst);
        desc = 1'b0;
        tick();   // enter SORT
        tick();   // phase 0
        tick();   // phase 1
        if (use_rst) rst = 1'b1;
        else         clr = 1'b1;
        tick();   // edge that would run phase 2
        rst = 1'b0; clr = 1'b0;
        model_clear();
        check(use_rst ? "abort_rst" : "abort_clr",
              64'({hand, hand_full, sorting, sort_done, addr_err, wr_rej}), 64'(0));
        tick();
        tick();
        check("abort_stays_fill", 64'({sorting, sort_done}), 64'(0));
    endtask

    task automatic fill_fixed();
        wr(0, 5); wr(1, 3); wr(2, 9); wr(3, 1); wr(4, 7);
    endtask

    task automatic fill_random(input int maxv);
        int a;
        while (!m_full()) begin
            case ($urandom_range(0, 7))
                0: wr($urandom_range(HS, 7), $urandom_range(0, maxv));
                1, 2: begin
                    a = $urandom_range(0, HS - 1);
                    if (m_valid[a]) wr(a, $urandom_range(0, maxv));
                end
                default: begin
                    do a = $urandom_range(0, HS - 1); while (m_valid[a]);
                    wr(a, $urandom_range(0, maxv));
                end
            endcase
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n;
        int q[$];
        logic [63:0] e8;
        logic [15:0] e2;

        rst = 1'b1; we = 1'b0; clr = 1'b0; desc = 1'b0; waddr = '0; card_in = '0;
        s2_rst = 1'b1; s2_we = 1'b0; s2_clr = 1'b0; s2_desc = 1'b0; s2_waddr = '0; s2_card = '0;
        s8_rst = 1'b1; s8_we = 1'b0; s8_clr = 1'b0; s8_desc = 1'b0; s8_waddr = '0; s8_card = '0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // ascending / descending with desc toggled mid-sort
        fill_fixed(); sort_run(1'b0, 1'b0); do_clear(1'b0);
        fill_fixed(); sort_run(1'b1, 1'b1); do_clear(1'b1);

        // rewrite of slot 0 and a duplicate pair
        wr(0, 4); wr(0, 12); wr(1, 12); wr(2, 2); wr(3, 30); wr(4, 8);
        sort_run(1'b0, 1'b0);
        check("dup_case_hand", 64'(hand), 64'({6'd30, 6'd12, 6'd12, 6'd8, 6'd2}));
        do_clear(1'b0);

        // out-of-range writes, then a write during SORT
        wr(1, 10); wr(5, 33); wr(7, 1); wr(0, 3); wr(6, 2); wr(2, 44); wr(3, 0); wr(4, 63);
        sort_run(1'b0, 1'b1); do_clear(1'b1);

        // abort mid-sort with clr, then with rst, then a clean run
        fill_fixed(); abort_run(1'b0);
        fill_fixed(); abort_run(1'b1);
        fill_fixed(); sort_run(1'b0, 1'b0); do_clear(1'b0);

        // randomized hands
        for (int r = 0; r < 25; r++) begin
            fill_random((r % 2 == 0) ? 15 : 63);
            sort_run(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            do_clear(1'($urandom_range(0, 1)));
        end

        // HAND_SIZE=2, reverse-sorted 255,254 ascending
        s2_rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            s2_we = 1'b1; s2_waddr = 1'(i); s2_card = 8'(255 - i);
            tick();
        end
        s2_we = 1'b0;
        for (int i = 0; i < 2; i++) e2[i*8 +: 8] = 8'(254 + i);
        s2_q.push_back(e2);
        n = 0;
        for (int k = 0; k < 30; k++) begin
            tick(); n++;
            if (s2_done) break;
        end
        check("s2_latency", 64'(n), 64'(3));
        check("s2_dup", 64'(s2_dup), 64'(0));

        // HAND_SIZE=8: reverse-sorted 255..248 ascending, then random descending
        s8_rst = 1'b0;
        for (int run = 0; run < 2; run++) begin
            q.delete();
            s8_desc = 1'(run);
            for (int i = 0; i < 8; i++) begin
                s8_we = 1'b1; s8_waddr = 3'(i);
                s8_card = (run == 0) ? 8'(255 - i) : 8'($urandom_range(0, 255));
                q.push_back(int'(s8_card));
                tick();
            end
            s8_we = 1'b0;
            if (run == 0) q.sort();
            else          q.rsort();
            for (int i = 0; i < 8; i++) e8[i*8 +: 8] = 8'(q[i]);
            s8_q.push_back(e8);
            n = 0;
            for (int k = 0; k < 30; k++) begin
                tick(); n++;
                if (s8_done) break;
            end
            check("s8_latency", 64'(n), 64'(9));
            s8_clr = 1'b1;
            tick();
            s8_clr = 1'b0;
            check("s8_cleared", 64'({s8_hand, s8_full}), 64'(0));
        end

        repeat (3) tick();
        check("queues_drained", 64'(exp_q.size() + s2_q.size() + s8_q.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
